// File: rtl/alzette_dec_iter.sv
// ---------------------------------------------------------------------------
// alzette_dec_iter
//   Iterative, handshaked inverse Alzette ARX-box (decryption direction).
//   A packed {y,x} ciphertext state and a 3-bit constant selector are latched
//   on acceptance. The four inverse quarters are then undone over 4/QPC cycles,
//   QPC quarters per cycle, in the order 0,1,2,3.
//
//   Parameters
//     QPC        quarters per cycle: 1, 2 or 4
//   Ports
//     g_clk      clock, all state on rising edge
//     g_resetn   asynchronous active-low reset
//     in_valid   request valid
//     in_ready   unit idle, request accepted when in_valid & in_ready
//     in_data    {y[63:32], x[31:0]} ciphertext state
//     in_imm     round-constant select (0..7)
//     out_valid  result valid, held until out_ready
//     out_ready  consumer accepts result
//     out_data   {y,x} after the full inverse (zero when not valid)
// ---------------------------------------------------------------------------
module alzette_dec_iter #(
    parameter int QPC = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [2:0]  in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    if (!(QPC == 1 || QPC == 2 || QPC == 4)) begin : g_bad_qpc
        $error("alzette_dec_iter: QPC must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [31:0] r_c;
    logic [1:0]  r_q;
    logic [31:0] w_x_nxt;
    logic [31:0] w_y_nxt;
    logic        w_last;
    logic        w_accept;

    function automatic logic [31:0] const_sel(input logic [2:0] sel);
        logic [31:0] c;
        unique case (sel)
            3'd0:    c = 32'hB7E15162;
            3'd1:    c = 32'hBF715880;
            3'd2:    c = 32'h38B4DA56;
            3'd3:    c = 32'h324E7738;
            3'd4:    c = 32'hBB1185EB;
            3'd5:    c = 32'h4F7C7B57;
            3'd6:    c = 32'hCFBFA1C8;
            default: c = 32'hC2B3293D;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] v, input int unsigned n);
        // n == 0 makes the left shift 32 wide, which yields zero: plain v.
        return (v >> n) | (v << (32 - n));
    endfunction

    // One inverse quarter k: x^=c; y^=ror(x,RX[k]); x-=ror(y,RY[k]).
    function automatic logic [63:0] quarter(input logic [31:0] x_in,
                                            input logic [31:0] y_in,
                                            input logic [31:0] c,
                                            input logic [1:0]  k);
        int unsigned rx;
        int unsigned ry;
        logic [31:0] x;
        logic [31:0] y;
        unique case (k)
            2'd0:    begin rx = 16; ry = 24; end
            2'd1:    begin rx = 31; ry = 0;  end
            2'd2:    begin rx = 17; ry = 17; end
            default: begin rx = 24; ry = 31; end
        endcase
        x = x_in ^ c;
        y = y_in ^ ror32(x, rx);
        x = x - ror32(y, ry);
        return {y, x};
    endfunction

    // Chain of QPC quarters starting at the current quarter index.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        for (int unsigned i = 0; i < QPC; i++) begin
            {w_y_nxt, w_x_nxt} = quarter(w_x_nxt, w_y_nxt, r_c, r_q + 2'(i));
        end
    end

    assign w_last   = (r_q == 2'(4 - QPC));
    assign w_accept = (r_state == ST_IDLE) && in_valid;

    // State register
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        out_data  = (r_state == ST_DONE) ? {r_y, r_x} : '0;
    end

    // Datapath: latch on accept, step quarters while running. The counter
    // advancing past quarter 3 wraps it back to zero for the next request.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_x <= '0;
            r_y <= '0;
            r_c <= '0;
            r_q <= '0;
        end else if (w_accept) begin
            r_x <= in_data[31:0];
            r_y <= in_data[63:32];
            r_c <= const_sel(in_imm);
            r_q <= '0;
        end else if (r_state == ST_RUN) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            r_q <= r_q + 2'(QPC);
        end
    end

endmodule
